// File: rtl/pc_redirect_if.sv
// Fetch-PC control bundle between the hazard/execute/fetch logic and pc_redirect_ctrl.
// The master side requests redirects and stalls; the slave side owns the fetch PC.
interface pc_redirect_if #(
   parameter int unsigned WordSize = 32
);
   logic                stall;
   logic                fetch_ready;
   logic                redir_valid;
   logic [WordSize-1:0] redir_addr;
   logic                trap_ack;
   logic [WordSize-1:0] pc;
   logic                fetch_valid;
   logic                flush;
   logic                trap_valid;
   logic [WordSize-1:0] trap_addr;

   modport master (
      output stall, fetch_ready, redir_valid, redir_addr, trap_ack,
      input  pc, fetch_valid, flush, trap_valid, trap_addr
   );

   modport slave (
      input  stall, fetch_ready, redir_valid, redir_addr, trap_ack,
      output pc, fetch_valid, flush, trap_valid, trap_addr
   );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Architectural fetch-PC owner: sequential fetch, branch/jump redirects with a timed
// flush window, and a held trap for misaligned redirect targets.
module pc_redirect_ctrl #(
   parameter int unsigned         WordSize    = 32,
   parameter logic [WordSize-1:0] ResetVector = '0,
   parameter logic [WordSize-1:0] TrapVector  = WordSize'(32'h0000_0100),
   parameter int unsigned         FlushCycles = 2
) (
   input logic          clk,
   input logic          rst,
   pc_redirect_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, TRAP = 2'd2} state_e;

   localparam logic [3:0]          CntReload = 4'(FlushCycles - 1);
   localparam logic [WordSize-1:0] PcStep    = WordSize'(4);

   state_e              state_q, state_d;
   logic [WordSize-1:0] pc_q, pc_d;
   logic [WordSize-1:0] trap_addr_q, trap_addr_d;
   logic                flush_q, flush_d;
   logic                trap_valid_q, trap_valid_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                redir_ok;
   logic                redir_bad;
   logic                fetch_valid;

   assign redir_ok  = bus.redir_valid & (bus.redir_addr[1:0] == 2'b00);
   assign redir_bad = bus.redir_valid & (bus.redir_addr[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         pc_q         <= ResetVector;
         flush_q      <= 1'b0;
         trap_valid_q <= 1'b0;
         trap_addr_q  <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         flush_q      <= flush_d;
         trap_valid_q <= trap_valid_d;
         trap_addr_q  <= trap_addr_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN, FLUSH: begin
            if (redir_bad) begin
               state_d = TRAP;
            end else if (redir_ok) begin
               state_d = FLUSH;
            end else if ((state_q == FLUSH) && (cnt_q == 4'd0)) begin
               state_d = RUN;
            end
         end
         TRAP: begin
            if (bus.trap_ack) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // flush_d defaults low so the trap entry pulse and the window end drop it cleanly.
   always_comb begin
      pc_d         = pc_q;
      flush_d      = 1'b0;
      trap_valid_d = trap_valid_q;
      trap_addr_d  = trap_addr_q;
      cnt_d        = cnt_q;
      fetch_valid  = (state_q == RUN) & ~bus.stall;
      case (state_q)
         RUN, FLUSH: begin
            if (redir_ok) begin
               pc_d    = bus.redir_addr;
               flush_d = 1'b1;
               cnt_d   = CntReload;
            end else if (redir_bad) begin
               trap_valid_d = 1'b1;
               trap_addr_d  = bus.redir_addr;
               flush_d      = 1'b1;
            end else if (state_q == FLUSH) begin
               if (cnt_q != 4'd0) begin
                  cnt_d   = cnt_q - 4'd1;
                  flush_d = 1'b1;
               end
            end else if (fetch_valid & bus.fetch_ready) begin
               pc_d = pc_q + PcStep;
            end
         end
         TRAP: begin
            if (bus.trap_ack) begin
               pc_d         = TrapVector;
               trap_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign bus.pc          = pc_q;
   assign bus.fetch_valid = fetch_valid;
   assign bus.flush       = flush_q;
   assign bus.trap_valid  = trap_valid_q;
   assign bus.trap_addr   = trap_addr_q;
endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Owns the architectural fetch PC and sequences it between sequential fetch and branch/jump redirects. Redirect targets come from the execute-stage branch address calculator, presented as a target address with a valid strobe. On a redirect the block squashes younger pipeline stages with a timed flush window. A misaligned target raises a trap that is held until acknowledged.

Parameters:
WordSize, 32, width of PC and addresses
ResetVector, 32'h0000_0000, PC value loaded on reset
TrapVector, 32'h0000_0100, PC loaded after trap_ack
FlushCycles, 2, cycles flush stays high per redirect (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
stall  in  1  freeze PC and fetch_valid (hazard unit)
fetch_ready  in  1  fetch stage accepts current pc
redir_valid  in  1  execute requests PC redirect this cycle
redir_addr  in  WordSize  redirect target (branch_addr/npc from execute)
trap_ack  in  1  trap handler accepts trap
pc  out  WordSize  current fetch address
fetch_valid  out  1  pc is a valid fetch request
flush  out  1  squash IF/ID/EX younger instructions
trap_valid  out  1  misaligned-target trap pending
trap_addr  out  WordSize  offending target address

Behaviour:
- Reset (async, rst=1): state=RUN, pc=ResetVector, flush=0, trap_valid=0, trap_addr=0, flush counter=0. fetch_valid=1 once rst deasserts.
- States: RUN, FLUSH, TRAP. All outputs are registered except fetch_valid, which is decoded from state and stall.
- fetch_valid = (state==RUN) & ~stall.
- RUN:
  - redir_valid with redir_addr[1:0]==0: pc<=redir_addr, flush<=1, counter<=FlushCycles-1, next state FLUSH. If FlushCycles==1, flush drops the following cycle and the state returns to RUN.
  - redir_valid with redir_addr[1:0]!=0: trap_valid<=1, trap_addr<=redir_addr, flush<=1 for one cycle, pc unchanged, next state TRAP.
  - Otherwise, if fetch_valid & fetch_ready: pc<=pc+4, with modulo 2^WordSize wrap (0xFFFF_FFFC -> 0x0).
  - Otherwise pc holds.
- Priority within a cycle: redir_valid > stall > fetch handshake. A fetch accepted in the same cycle as a redirect is discarded: pc takes the target, not pc+4, and flush covers the accepted instruction.
- FLUSH:
  - flush=1. pc holds the target and fetch_valid=0.
  - The counter decrements each cycle. At counter==0, flush<=0 and the next state is RUN.
  - stall does not extend the flush.
  - A new aligned redir_valid during FLUSH reloads pc and the counter and stays in FLUSH (the latest redirect wins).
  - A new misaligned redir_valid during FLUSH moves to TRAP, as from RUN.
- TRAP:
  - trap_valid=1 and trap_addr is stable; fetch_valid=0. flush is 1 on the entry cycle only, then 0. redir_valid is ignored.
  - trap_ack: pc<=TrapVector, trap_valid<=0, next state RUN. The first fetch from TrapVector is the cycle after the ack.
  - trap_ack is ignored outside TRAP.
- A stall in RUN holds pc and forces fetch_valid=0 the same cycle.
- Reset asserted mid-FLUSH or mid-TRAP aborts immediately to the reset values, with no residual flush pulse.
- Alignment check covers bits [1:0] only (no compressed ISA).

Test Plan:
- Reset release, fetch_ready=1 for 4 cycles -> pc sequence 0x0, 0x4, 0x8, 0xC with fetch_valid=1 throughout; flush=0.
- At pc=0x8, redir_valid=1 with redir_addr=0x40 and fetch_ready=1 -> next cycle pc=0x40 and flush=1 for exactly 2 cycles with fetch_valid=0. The third cycle has fetch_valid=1 at pc=0x40, then 0x44.
- Redirect to 0x40, then one cycle later a redirect to 0x80 -> pc=0x80, and flush stays high 2 cycles after the second redirect (3 cycles total).
- redir_addr=0x42 -> trap_valid=1, trap_addr=0x42, one-cycle flush, pc unchanged, fetch_valid=0. Hold 5 cycles, and a redir_valid to 0x10 during the hold is ignored. Then trap_ack -> next cycle pc=0x100, trap_valid=0, fetch_valid=1.
- stall=1 for 3 cycles at pc=0x20 with fetch_ready=1 -> pc stays 0x20 and fetch_valid=0. Release the stall -> 0x20 is accepted, then 0x24. Stall and redirect to 0x60 together -> pc=0x60 and flush asserted.
- Assert rst during FLUSH and during TRAP -> pc=0x0, flush=0 and trap_valid=0 asynchronously, before the next clock edge. Also, pc at 0xFFFF_FFFC with a fetch accepted -> pc wraps to 0x0.
